run_sequencer: RTL
==================

# run_sequencer

Session controller for the single-core matrix multiplier. It takes a host byte stream and loads the program into instruction memory and the matrix operands into data memory while the core is held in reset. It then releases the core, waits for its `end_op` pulse (with a watchdog), and streams the result region of data memory back to the host. It owns the shared memory write/address port and muxes it between the host path and the core.

## Interface
- `ADDR_W`, 8: memory address width; also the width of all length fields.
- `DATA_W`, 8: memory and stream data width.
- `TIMEOUT_W`, 16: RUN watchdog counter width. Timeout fires after 2^TIMEOUT_W−1 cycles.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: session request, sampled in IDLE only.
- `im_len`, `dm_len` in ADDR_W: byte counts to load into IM and DM; captured on start.
- `res_base`, `res_len` in ADDR_W: base address and byte count of the DM result region; captured on start.
- `rx_data` in DATA_W, `rx_valid` in 1, `rx_ready` out 1: host input stream.
- `tx_data` out DATA_W, `tx_valid` out 1, `tx_ready` in 1: host output stream.
- `core_rst` out 1: holds the core in reset (1 = held).
- `end_op` in 1: core completion pulse.
- `core_addr` in ADDR_W, `core_wdata` in DATA_W, `core_dm_wr` in 1: core memory port.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `im_wr` out 1, `dm_wr` out 1: muxed memory port.
- `dm_rdata` in DATA_W: DM read data, synchronous, 1-cycle latency.
- `busy` out 1, `done` out 1, `err` out 1: status.

## Operation
- States: IDLE, LOAD_IM, LOAD_DM, RUN, RD, TX, DONE.
- **IDLE**
  - `start`=1 captures the config fields and clears `err`.
  - Next state is the first non-empty phase: LOAD_IM if `im_len`≠0, else LOAD_DM if `dm_len`≠0, else RUN.
- **LOAD_IM / LOAD_DM**
  - `rx_ready`=1. Byte counter `cnt` starts at 0.
  - `mem_addr`=`cnt` and `mem_wdata`=`rx_data`, both combinational.
  - `im_wr` (or `dm_wr`) = `rx_valid`&`rx_ready`, so the write lands on the handshake edge.
  - On the accept where `cnt`=len−1: clear `cnt` and advance (LOAD_IM→LOAD_DM or RUN; LOAD_DM→RUN).
  - Loads always start at address 0.
- **RUN**
  - `core_rst`=0.
  - The memory port passes the core through: `mem_addr`=`core_addr`, `mem_wdata`=`core_wdata`, `dm_wr`=`core_dm_wr`, `im_wr`=0.
  - The watchdog increments every cycle.
  - `end_op`=1 → RD, or DONE if `res_len`=0.
  - Watchdog all-ones without `end_op` → set `err`, go to DONE.
  - `end_op` in the same cycle as the timeout → `end_op` wins and `err` stays 0.
  - `core_rst` returns to 1 on the cycle after leaving RUN.
- **RD**
  - `mem_addr` = (`res_base`+`idx`) mod 2^ADDR_W, wrapping at the top of memory. Always → TX.
- **TX**
  - On entry, capture `dm_rdata` into `tx_data` and assert `tx_valid`.
  - Hold `tx_data` and `tx_valid` stable until `tx_ready`.
  - On handshake: `idx`++; if `idx`=`res_len`−1 → DONE, else → RD.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored.
- `rx_ready`=0 and `tx_valid`=0 outside their states.
- `err` is sticky until the next accepted start.

## Timing
- Reset values: `core_rst`=1; all other outputs 0 (`rx_ready`, `tx_valid`, `tx_data`, `mem_addr`, `mem_wdata`, `im_wr`, `dm_wr`, `busy`, `done`, `err`). State = IDLE.
- Reset mid-session aborts immediately. The core is re-held in reset and no partial result is emitted.
- `start` high at edge N → `rx_ready`=1 from cycle N+1.
- Load rate: 1 byte/cycle with `rx_valid` held high.
- Last accepted DM byte at edge M → `core_rst`=0 during cycle M+1.
- `end_op` at edge K → RD in K+1, first `tx_valid` in K+2.
- Drain rate: 1 byte per 2 cycles minimum; each `tx_ready` stall adds one cycle per stall cycle.
- Last TX handshake at edge L → `done`=1 in cycle L+1, `busy`=0 in L+2.

## Test plan
- **Full session:** im_len=3 (0x10,0x20,0x30), dm_len=2 (0x05,0x07), core model writes DM[4]=0x23 then pulses end_op, res_base=4, res_len=1.
  - IM[0..2]=0x10,0x20,0x30 and DM[0..1]=0x05,0x07.
  - tx emits 0x23; done pulses once.
- **Back-pressure:** rx_valid toggles 1,0,1,1 during load; tx_ready low for 3 cycles in TX.
  - Writes occur only on handshakes.
  - tx_data is stable while stalled; no bytes are lost or duplicated.
- **Zero lengths:** im_len=dm_len=res_len=0, start.
  - RUN entered at cycle N+1.
  - end_op → done with no tx_valid ever asserted.
- **Watchdog:** TIMEOUT_W=4, end_op never asserted.
  - err=1 and done pulse 15 cycles after RUN entry; core_rst back to 1.
  - Variant: end_op on the 15th cycle → err=0.
- **Wrap:** res_base=0xFE, res_len=3.
  - Read addresses 0xFE, 0xFF, 0x00, in order.
- **Reset/ignore:** rst asserted during LOAD_DM.
  - All outputs return to reset values; core_rst=1.
  - A start pulse during RUN is ignored, with config fields unchanged.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: loads IM/DM from a host stream, runs the core under a
// watchdog, then streams the DM result region back to the host.
module run_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] im_len,
  input  logic [ADDR_W-1:0] dm_len,
  input  logic [ADDR_W-1:0] res_base,
  input  logic [ADDR_W-1:0] res_len,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              core_rst,
  input  logic              end_op,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_dm_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              im_wr,
  output logic              dm_wr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_IM, LOAD_DM, RUN, RD, TX, DONE
  } state_t;

  localparam logic [ADDR_W-1:0]    AONE = ADDR_W'(1);
  localparam logic [TIMEOUT_W-1:0] TONE = TIMEOUT_W'(1);

  state_t state, state_d;

  logic [ADDR_W-1:0]    im_len_q, dm_len_q;
  logic [ADDR_W-1:0]    res_base_q, res_len_q;
  logic [ADDR_W-1:0]    cnt, idx;
  logic [TIMEOUT_W-1:0] wd;
  logic [DATA_W-1:0]    tx_q;
  logic                 tx_first;
  logic                 err_q;
  logic                 rx_take, tx_take, wd_hit;

  assign rx_take = rx_valid & rx_ready;
  assign tx_take = tx_valid & tx_ready;
  assign wd_hit  = &wd;
  assign err     = err_q;

  // Read data arrives during the first TX cycle; held in tx_q afterwards.
  assign tx_data = (state == TX && tx_first) ? dm_rdata : tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    core_rst  = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    im_wr     = 1'b0;
    dm_wr     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (im_len != '0)      state_d = LOAD_IM;
          else if (dm_len != '0) state_d = LOAD_DM;
          else                   state_d = RUN;
        end
      end
      LOAD_IM: begin
        rx_ready  = 1'b1;
        mem_addr  = cnt;
        mem_wdata = rx_data;
        im_wr     = rx_valid;
        if (rx_take && cnt == im_len_q - AONE)
          state_d = (dm_len_q != '0) ? LOAD_DM : RUN;
      end
      LOAD_DM: begin
        rx_ready  = 1'b1;
        mem_addr  = cnt;
        mem_wdata = rx_data;
        dm_wr     = rx_valid;
        if (rx_take && cnt == dm_len_q - AONE)
          state_d = RUN;
      end
      RUN: begin
        core_rst  = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        dm_wr     = core_dm_wr;
        if (end_op)
          state_d = (res_len_q != '0) ? RD : DONE;
        else if (wd_hit)
          state_d = DONE;
      end
      RD: begin
        mem_addr = res_base_q + idx;
        state_d  = TX;
      end
      TX: begin
        mem_addr = res_base_q + idx;
        tx_valid = 1'b1;
        if (tx_take)
          state_d = (idx == res_len_q - AONE) ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_len_q   <= '0;
      dm_len_q   <= '0;
      res_base_q <= '0;
      res_len_q  <= '0;
      cnt        <= '0;
      idx        <= '0;
      wd         <= '0;
      tx_q       <= '0;
      tx_first   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        im_len_q   <= im_len;
        dm_len_q   <= dm_len;
        res_base_q <= res_base;
        res_len_q  <= res_len;
        err_q      <= 1'b0;
      end
      if ((state == LOAD_IM || state == LOAD_DM) && rx_take)
        cnt <= (state_d != state) ? '0 : cnt + AONE;
      // wd counts RUN cycles 1-based so all-ones marks the last allowed one
      if (state_d == RUN && state != RUN) wd <= TONE;
      else if (state == RUN)              wd <= wd + TONE;
      if (state == RUN && !end_op && wd_hit)
        err_q <= 1'b1;
      if (state == RUN)
        idx <= '0;
      else if (state == TX && tx_take)
        idx <= idx + AONE;
      tx_first <= (state == RD);
      if (state == TX && tx_first)
        tx_q <= dm_rdata;
    end
  end

endmodule
